// File: rtl/ccx_mem_if.sv
// CCX memory bus: request fields from master, response from slave.
// One instance per requester port and one for the memory port.
interface ccx_mem_if #(
  parameter int AW = 39,
  parameter int DW = 64
);
  logic          req;
  logic          rtype;
  logic [AW-1:0] addr;
  logic          wen;
  logic [DW/8-1:0] strb;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (
    output req, rtype, addr,
    output wen, strb, wdata,
    input  gnt, err, rdata
  );

  modport slave (
    input  req, rtype, addr,
    input  wen, strb, wdata,
    output gnt, err, rdata
  );
endinterface

// File: rtl/ccx_mem_arbiter.sv
// Two-requester round-robin arbiter onto one CCX memory port.
// Ownership locks from req to gnt; optional response timeout.
module ccx_mem_arbiter #(
  parameter int AW      = 39,
  parameter int DW      = 64,
  parameter int TIMEOUT = 0
) (
  input  logic     g_clk,
  input  logic     g_resetn,
  ccx_mem_if.slave  r0,
  ccx_mem_if.slave  r1,
  ccx_mem_if.master m,
  output logic     owner
);

  localparam int SW = DW / 8;
  localparam logic [15:0] TO = 16'(TIMEOUT);
  localparam bit TOEN = (TIMEOUT != 0);

  typedef enum logic {
    IDLE,
    LOCKED
  } st_t;

  st_t         st;
  logic        own_q;
  logic        last_q;
  logic [15:0] tcnt;

  logic          any;
  logic          win;
  logic          sel;
  logic          oreq;
  logic          hit;
  logic          tmo;
  logic          mreq;
  logic          done;
  logic          rsp;
  logic [AW-1:0] addr;
  logic [SW-1:0] strb;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdat;

  // Winner pick, owner select and timeout detection
  always_comb begin
    any  = r0.req | r1.req;
    win  = (r0.req & r1.req) ? ~last_q : r1.req;
    sel  = own_q;
    if (!g_resetn)
      sel = 1'b0;
    else if (st == IDLE && any)
      sel = win;
    oreq = sel ? r1.req : r0.req;
    hit  = oreq & m.gnt;
    tmo  = TOEN && g_resetn &&
           st == LOCKED &&
           tcnt == TO && !hit;
    mreq = g_resetn & oreq & ~tmo;
    done = mreq & m.gnt;
    rsp  = done | tmo;
    addr  = sel ? r1.addr : r0.addr;
    strb  = sel ? r1.strb : r0.strb;
    wdata = sel ? r1.wdata : r0.wdata;
    rdat  = (g_resetn && !tmo) ?
            m.rdata : '0;
  end

  assign owner   = sel;
  assign m.req   = mreq;
  assign m.rtype = sel ? r1.rtype : r0.rtype;
  assign m.wen   = sel ? r1.wen : r0.wen;
  assign m.addr  = addr;
  assign m.strb  = strb;
  assign m.wdata = wdata;

  assign r0.gnt   = ~sel & rsp;
  assign r1.gnt   = sel & rsp;
  assign r0.err   = ~sel & g_resetn &
                    (tmo | m.err);
  assign r1.err   = sel & g_resetn &
                    (tmo | m.err);
  assign r0.rdata = sel ? '0 : rdat;
  assign r1.rdata = sel ? rdat : '0;

  // Arbitration state, lock owner and timeout counter
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      st     <= IDLE;
      own_q  <= 1'b0;
      last_q <= 1'b1;
      tcnt   <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (any) begin
            if (done) begin
              last_q <= win;
            end else begin
              own_q <= win;
              st    <= LOCKED;
              tcnt  <= 16'd1;
            end
          end
        end
        LOCKED: begin
          if (rsp) begin
            last_q <= own_q;
            st     <= IDLE;
            tcnt   <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccx_mem_arbiter.sv
// Directed bench for ccx_mem_arbiter: TIMEOUT=0 and TIMEOUT=4
// instances share stimulus.
module tb_ccx_mem_arbiter;
  localparam int AW = 39;
  localparam int DW = 64;

  logic g_clk;
  logic g_resetn;
  logic owner;
  logic owner_t;
  int   checks;
  int   errors;
  int   n0;
  int   n1;

  ccx_mem_if #(.AW(AW), .DW(DW)) r0 ();
  ccx_mem_if #(.AW(AW), .DW(DW)) r1 ();
  ccx_mem_if #(.AW(AW), .DW(DW)) m ();
  ccx_mem_if #(.AW(AW), .DW(DW)) r0t ();
  ccx_mem_if #(.AW(AW), .DW(DW)) r1t ();
  ccx_mem_if #(.AW(AW), .DW(DW)) mt ();

  assign r0t.req   = r0.req;
  assign r0t.rtype = r0.rtype;
  assign r0t.addr  = r0.addr;
  assign r0t.wen   = r0.wen;
  assign r0t.strb  = r0.strb;
  assign r0t.wdata = r0.wdata;
  assign r1t.req   = r1.req;
  assign r1t.rtype = r1.rtype;
  assign r1t.addr  = r1.addr;
  assign r1t.wen   = r1.wen;
  assign r1t.strb  = r1.strb;
  assign r1t.wdata = r1.wdata;
  assign mt.gnt    = m.gnt;
  assign mt.err    = m.err;
  assign mt.rdata  = m.rdata;

  ccx_mem_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(0)
  ) dut (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
    .r0(r0),
    .r1(r1),
    .m(m),
    .owner(owner)
  );

  ccx_mem_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(4)
  ) dut_t (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
    .r0(r0t),
    .r1(r1t),
    .m(mt),
    .owner(owner_t)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_in();
    r0.req = 0; r0.rtype = 0;
    r0.addr = '0; r0.wen = 0;
    r0.strb = '0; r0.wdata = '0;
    r1.req = 0; r1.rtype = 1;
    r1.addr = '0; r1.wen = 0;
    r1.strb = '0; r1.wdata = '0;
    m.gnt = 0; m.err = 0;
    m.rdata = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n0 = 0;
    n1 = 0;
    idle_in();
    g_resetn = 0;
    r0.req = 1;
    r1.req = 1;
    m.gnt = 1;
    m.err = 1;
    #2;
    chk("rst_mreq", m.req, 0);
    chk("rst_g0", r0.gnt, 0);
    chk("rst_g1", r1.gnt, 0);
    chk("rst_e0", r0.err, 0);
    chk("rst_own", owner, 0);
    idle_in();
    #10;
    g_resetn = 1;

    // zero-wait single requester
    tick();
    r0.req = 1;
    r0.addr = 39'h10;
    m.gnt = 1;
    m.rdata = 64'hDEAD;
    #1;
    chk("zw_mreq", m.req, 1);
    chk("zw_addr", m.addr, 39'h10);
    chk("zw_g0", r0.gnt, 1);
    chk("zw_rd0", r0.rdata, 64'hDEAD);
    chk("zw_g1", r1.gnt, 0);
    tick();
    idle_in();
    r1.req = 1;
    r1.addr = 39'h20;
    m.gnt = 1;
    m.rdata = 64'hBEEF;
    #1;
    chk("zw_idle_own", owner, 1);
    chk("zw_idle_g1", r1.gnt, 1);
    chk("zw_idle_rd1", r1.rdata, 64'hBEEF);
    chk("zw_idle_rd0", r0.rdata, 0);
    tick();
    idle_in();

    // contention after reset, latency 3
    g_resetn = 0;
    #1;
    g_resetn = 1;
    tick();
    r0.req = 1;
    r0.addr = 39'h100;
    r1.req = 1;
    r1.addr = 39'h200;
    #1;
    chk("ct0_own", owner, 0);
    chk("ct0_addr", m.addr, 39'h100);
    chk("ct0_g1", r1.gnt, 0);
    chk("ct0_g0", r0.gnt, 0);
    tick();
    chk("ct1_own", owner, 0);
    chk("ct1_addr", m.addr, 39'h100);
    chk("ct1_g1", r1.gnt, 0);
    tick();
    m.gnt = 1;
    m.rdata = 64'h1111;
    #1;
    chk("ct2_addr", m.addr, 39'h100);
    chk("ct2_g0", r0.gnt, 1);
    chk("ct2_rd0", r0.rdata, 64'h1111);
    chk("ct2_g1", r1.gnt, 0);
    chk("ct2_rd1", r1.rdata, 0);
    tick();
    r0.req = 0;
    m.gnt = 1;
    m.rdata = 64'h2222;
    #1;
    chk("ct3_own", owner, 1);
    chk("ct3_addr", m.addr, 39'h200);
    chk("ct3_g1", r1.gnt, 1);
    chk("ct3_rd1", r1.rdata, 64'h2222);
    tick();
    idle_in();

    // round-robin, 1-cycle latency
    r0.req = 1;
    r0.addr = 39'h300;
    r1.req = 1;
    r1.addr = 39'h400;
    for (int i = 0; i < 6; i++) begin
      tick();
      m.gnt = 0;
      #1;
      chk("rr_own", owner, 64'(i % 2));
      chk("rr_addr", m.addr,
          (i % 2) ? 39'h400 : 39'h300);
      tick();
      m.gnt = 1;
      #1;
      chk("rr_gown", owner, 64'(i % 2));
      chk("rr_g0", r0.gnt, 64'(i % 2 == 0));
      chk("rr_g1", r1.gnt, 64'(i % 2 == 1));
      n0 += int'(r0.gnt);
      n1 += int'(r1.gnt);
    end
    tick();
    idle_in();
    chk("rr_n0", n0, 3);
    chk("rr_n1", n1, 3);

    // lock stability with r1 owning
    tick();
    r1.req = 1;
    r1.addr = 39'h500;
    #1;
    chk("lk0_own", owner, 1);
    tick();
    r0.req = 1;
    r0.addr = 39'h600;
    #1;
    chk("lk1_own", owner, 1);
    chk("lk1_addr", m.addr, 39'h500);
    chk("lk1_g0", r0.gnt, 0);
    tick();
    chk("lk2_own", owner, 1);
    chk("lk2_addr", m.addr, 39'h500);
    chk("lk2_g0", r0.gnt, 0);
    tick();
    m.gnt = 1;
    m.rdata = 64'h3333;
    #1;
    chk("lk3_g1", r1.gnt, 1);
    chk("lk3_g0", r0.gnt, 0);
    chk("lk3_rd1", r1.rdata, 64'h3333);
    chk("lk3_rd0", r0.rdata, 0);
    tick();
    r1.req = 0;
    #1;
    chk("lk4_own", owner, 0);
    chk("lk4_addr", m.addr, 39'h600);
    chk("lk4_g0", r0.gnt, 1);
    tick();
    idle_in();

    // timeout on the TIMEOUT=4 instance
    g_resetn = 0;
    #1;
    g_resetn = 1;
    tick();
    r0.req = 1;
    r0.addr = 39'h700;
    r1.req = 1;
    r1.addr = 39'h800;
    m.rdata = 64'hBEEF;
    #1;
    chk("to0_own", owner_t, 0);
    chk("to0_mreq", mt.req, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("to_wait_g0", r0t.gnt, 0);
      chk("to_wait_mreq", mt.req, 1);
    end
    tick();
    chk("to4_mreq", mt.req, 0);
    chk("to4_g0", r0t.gnt, 1);
    chk("to4_e0", r0t.err, 1);
    chk("to4_rd0", r0t.rdata, 0);
    chk("to4_g1", r1t.gnt, 0);
    chk("to4_nto_mreq", m.req, 1);
    chk("to4_nto_g0", r0.gnt, 0);
    tick();
    r0.req = 0;
    m.gnt = 1;
    m.rdata = 64'h4444;
    #1;
    chk("to5_own", owner_t, 1);
    chk("to5_addr", mt.addr, 39'h800);
    chk("to5_g1", r1t.gnt, 1);
    chk("to5_e1", r1t.err, 0);
    chk("to5_rd1", r1t.rdata, 64'h4444);
    tick();
    idle_in();

    // reset in the middle of a locked wait
    g_resetn = 0;
    #1;
    g_resetn = 1;
    tick();
    r0.req = 1;
    m.gnt = 1;
    #1;
    chk("rl_pre_g0", r0.gnt, 1);
    tick();
    idle_in();
    r1.req = 1;
    r1.addr = 39'h900;
    #1;
    chk("rl0_own", owner, 1);
    tick();
    chk("rl1_mreq", m.req, 1);
    chk("rl1_own", owner, 1);
    tick();
    #1;
    g_resetn = 0;
    #1;
    chk("rl_mreq", m.req, 0);
    chk("rl_own", owner, 0);
    chk("rl_g1", r1.gnt, 0);
    idle_in();
    #2;
    g_resetn = 1;
    tick();
    m.gnt = 1;
    m.rdata = 64'h5555;
    #1;
    chk("rl_late_g0", r0.gnt, 0);
    chk("rl_late_g1", r1.gnt, 0);
    chk("rl_late_mreq", m.req, 0);
    tick();
    r0.req = 1;
    r1.req = 1;
    m.gnt = 1;
    #1;
    chk("rl_ct_own", owner, 0);
    chk("rl_ct_g0", r0.gnt, 1);
    chk("rl_ct_g1", r1.gnt, 0);
    tick();
    idle_in();

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end
endmodule
